// File: rtl/heart_hud_ctrl.sv
// Lives HUD sequencer: tracks remaining lives, blinks the heart just lost, raises
// game over, and drives a 2-stage heart sprite pipeline (ROM address -> palette index).
module heart_hud_ctrl #(
    parameter int MAX_LIVES    = 3,
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int X0           = 16,
    parameter int Y0           = 16,
    parameter int GAP          = 4,
    parameter int BLINK_FRAMES = 32,
    parameter int TRANSP_IDX   = 0,
    localparam int AW          = $clog2(SPR_W * SPR_H),
    localparam int LW          = $clog2(MAX_LIVES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic          life_lost,
    input  logic          restart,
    output logic [AW-1:0] rom_addr,
    input  logic [3:0]    rom_data,
    output logic [3:0]    pal_index,
    output logic          heart_on,
    output logic [LW-1:0] lives,
    output logic          game_over
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {PLAY, BLINK, GAME_OVER} state_t;

    state_t        state_reg;
    logic [LW-1:0] lives_reg;
    logic [LW-1:0] blink_slot_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          game_over_reg;

    logic          hit_reg;
    logic          vis_reg;

    logic [9:0]           dy;
    logic                 y_in;
    logic [9:0]           dx [MAX_LIVES];
    logic [MAX_LIVES-1:0] slot_hit;
    logic [MAX_LIVES-1:0] slot_vis;

    logic          hit_next;
    logic          vis_next;
    logic [AW-1:0] addr_next;
    logic          loss;

    // Unsigned offsets: pixels left of / above a heart wrap to large values and miss.
    assign dy   = draw_y - 10'(Y0);
    assign y_in = dy < 10'(SPR_H);

    for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_slot
        localparam int XI = X0 + gi * (SPR_W + GAP);
        assign dx[gi]       = draw_x - 10'(XI);
        assign slot_hit[gi] = y_in && (dx[gi] < 10'(SPR_W));
        assign slot_vis[gi] = (state_reg != GAME_OVER) &&
                              ((LW'(gi) < lives_reg) ||
                               ((state_reg == BLINK) && (LW'(gi) == blink_slot_reg) &&
                                blink_cnt_reg[2]));
    end

    // Hearts never overlap, so at most one slot hits.
    always_comb begin
        hit_next  = 1'b0;
        vis_next  = 1'b0;
        addr_next = '0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (slot_hit[i]) begin
                hit_next  = 1'b1;
                vis_next  = slot_vis[i];
                addr_next = AW'(int'(dy) * SPR_W + int'(dx[i]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_reg   <= 1'b0;
            vis_reg   <= 1'b0;
            rom_addr  <= '0;
            pal_index <= '0;
            heart_on  <= 1'b0;
        end else begin
            hit_reg   <= hit_next;
            vis_reg   <= vis_next;
            rom_addr  <= addr_next;
            pal_index <= rom_data;
            heart_on  <= hit_reg & vis_reg & (rom_data != 4'(TRANSP_IDX));
        end
    end

    assign loss = life_lost && (lives_reg != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= PLAY;
            lives_reg      <= LW'(MAX_LIVES);
            blink_slot_reg <= '0;
            blink_cnt_reg  <= '0;
            game_over_reg  <= 1'b0;
        end else if (restart) begin
            state_reg     <= PLAY;
            lives_reg     <= LW'(MAX_LIVES);
            blink_cnt_reg <= '0;
            game_over_reg <= 1'b0;
        end else begin
            case (state_reg)
                PLAY, BLINK: begin
                    if (loss) begin
                        // A new loss replaces any heart still blinking.
                        lives_reg      <= lives_reg - LW'(1);
                        blink_slot_reg <= lives_reg - LW'(1);
                        blink_cnt_reg  <= BW'(BLINK_FRAMES);
                        state_reg      <= BLINK;
                    end else if ((state_reg == BLINK) && frame_start) begin
                        if (blink_cnt_reg == BW'(1)) begin
                            blink_cnt_reg <= '0;
                            if (lives_reg != '0) begin
                                state_reg <= PLAY;
                            end else begin
                                state_reg     <= GAME_OVER;
                                game_over_reg <= 1'b1;
                            end
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg - BW'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    game_over_reg <= 1'b1;
                end
                default: begin
                    state_reg <= PLAY;
                end
            endcase
        end
    end

    assign lives     = lives_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_heart_hud_ctrl.sv
// Directed bench for heart_hud_ctrl: pixel vector table, row sweep, and hand-written
// life/blink/restart/reset sequences. The ROM is modelled combinationally from rom_addr.
module tb_heart_hud_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       life_lost;
    logic       restart;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] pal_index;
    logic       heart_on;
    logic [1:0] lives;
    logic       game_over;

    logic       ovr_en;
    logic [3:0] ovr_val;

    int n_chk  = 0;
    int n_fail = 0;

    heart_hud_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .life_lost  (life_lost),
        .restart    (restart),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pal_index  (pal_index),
        .heart_on   (heart_on),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Sprite content: always opaque unless overridden, low address bits visible in the index.
    always_comb rom_data = ovr_en ? ovr_val : {rom_addr[1:0], 2'b01};

    typedef struct {
        int x;
        int y;
        bit on;
        int addr;
        int pal;
    } vec_t;

    vec_t vecs [17];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic pix(input int x, input int y, output logic on, output logic [3:0] pal,
                       output logic [7:0] addr);
        draw_x = 10'(x);
        draw_y = 10'(y);
        tick;
        addr = rom_addr;
        tick;
        on  = heart_on;
        pal = pal_index;
    endtask

    task automatic pix_on(input string name, input int x, input int y, input bit exp);
        logic       on;
        logic [3:0] pal;
        logic [7:0] addr;
        pix(x, y, on, pal, addr);
        chk(name, 32'(on), 32'(exp));
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic lose;
        life_lost = 1'b1;
        tick;
        life_lost = 1'b0;
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick;
        restart = 1'b0;
    endtask

    initial begin
        logic       on;
        logic [3:0] pal;
        logic [7:0] addr;
        bit         exp_on;
        int         px;

        vecs[0]  = '{15, 20, 0, 0, 1};
        vecs[1]  = '{16, 20, 1, 64, 1};
        vecs[2]  = '{31, 20, 1, 79, 13};
        vecs[3]  = '{32, 20, 0, 0, 1};
        vecs[4]  = '{35, 20, 0, 0, 1};
        vecs[5]  = '{36, 20, 1, 64, 1};
        vecs[6]  = '{51, 20, 1, 79, 13};
        vecs[7]  = '{52, 20, 0, 0, 1};
        vecs[8]  = '{56, 20, 1, 64, 1};
        vecs[9]  = '{71, 20, 1, 79, 13};
        vecs[10] = '{72, 20, 0, 0, 1};
        vecs[11] = '{20, 15, 0, 0, 1};
        vecs[12] = '{20, 16, 1, 4, 1};
        vecs[13] = '{20, 31, 1, 244, 1};
        vecs[14] = '{20, 32, 0, 0, 1};
        vecs[15] = '{18, 21, 1, 82, 9};
        vecs[16] = '{1000, 1000, 0, 0, 1};

        reset_n     = 1'b0;
        frame_start = 1'b0;
        life_lost   = 1'b0;
        restart     = 1'b0;
        draw_x      = 10'd20;
        draw_y      = 10'd20;
        ovr_en      = 1'b0;
        ovr_val     = 4'd0;

        // Reset state, with a heart pixel on the inputs the whole time.
        tick;
        tick;
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_game_over", 32'(game_over), 32'd0);
        chk("reset_heart_on", 32'(heart_on), 32'd0);
        chk("reset_pal_index", 32'(pal_index), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        reset_n = 1'b1;

        // Pixel table with lives=3.
        for (int i = 0; i < 17; i++) begin
            pix(vecs[i].x, vecs[i].y, on, pal, addr);
            chk($sformatf("vec%0d_addr(%0d,%0d)", i, vecs[i].x, vecs[i].y), 32'(addr),
                32'(vecs[i].addr));
            chk($sformatf("vec%0d_on", i), 32'(on), 32'(vecs[i].on));
            chk($sformatf("vec%0d_pal", i), 32'(pal), 32'(vecs[i].pal));
        end

        // Streaming sweep of row 20: output for column x appears two edges after it is driven.
        draw_y = 10'd20;
        for (int x = 0; x <= 100; x++) begin
            draw_x = 10'(x);
            tick;
            if (x >= 1) begin
                px = x - 1;
                exp_on = (px >= 16 && px <= 31) || (px >= 36 && px <= 51) ||
                         (px >= 56 && px <= 71);
                chk($sformatf("sweep_x%0d", px), 32'(heart_on), 32'(exp_on));
            end
        end

        // ROM override: opaque index 7 then transparent index.
        ovr_en  = 1'b1;
        ovr_val = 4'd7;
        pix(18, 21, on, pal, addr);
        chk("rom7_addr", 32'(addr), 32'd82);
        chk("rom7_pal", 32'(pal), 32'd7);
        chk("rom7_on", 32'(on), 32'd1);
        ovr_val = 4'd0;
        pix(18, 21, on, pal, addr);
        chk("rom0_pal", 32'(pal), 32'd0);
        chk("rom0_on", 32'(on), 32'd0);
        ovr_en = 1'b0;

        // Single loss: heart 2 blinks on bit 2 of the remaining-frame count, then vanishes.
        lose;
        chk("loss1_lives", 32'(lives), 32'd2);
        for (int n = 0; n <= 32; n++) begin
            exp_on = (n < 32) ? bit'(((32 - n) >> 2) & 1) : 1'b0;
            pix_on($sformatf("blink_n%0d", n), 60, 20, exp_on);
            if (n < 32) frame;
        end
        pix_on("after_blink_heart1", 40, 20, 1'b1);
        chk("after_blink_lives", 32'(lives), 32'd2);
        chk("after_blink_game_over", 32'(game_over), 32'd0);

        // Three losses two frames apart.
        do_restart;
        chk("restart_lives", 32'(lives), 32'd3);
        lose;
        chk("multi_lives2", 32'(lives), 32'd2);
        frame;
        frame;
        lose;
        chk("multi_lives1", 32'(lives), 32'd1);
        pix_on("multi_h2_gone", 60, 20, 1'b0);
        pix_on("multi_h1_cnt32", 40, 20, 1'b0);
        pix_on("multi_h0_solid", 20, 20, 1'b1);
        frame;
        pix_on("multi_h1_cnt31", 40, 20, 1'b1);
        pix_on("multi_h2_still_gone", 60, 20, 1'b0);
        frame;
        lose;
        chk("multi_lives0", 32'(lives), 32'd0);
        frame;
        pix_on("multi_h0_cnt31", 20, 20, 1'b1);
        pix_on("multi_h1_gone", 40, 20, 1'b0);
        for (int n = 1; n < 31; n++) frame;
        chk("multi_go_before_last", 32'(game_over), 32'd0);
        frame;
        chk("multi_game_over", 32'(game_over), 32'd1);
        chk("multi_go_lives", 32'(lives), 32'd0);
        lose;
        chk("go_loss_lives", 32'(lives), 32'd0);
        chk("go_loss_game_over", 32'(game_over), 32'd1);
        pix_on("go_h0_off", 20, 20, 1'b0);

        // Restart and loss in the same cycle while in game over: restart wins.
        restart   = 1'b1;
        life_lost = 1'b1;
        tick;
        restart   = 1'b0;
        life_lost = 1'b0;
        chk("rs_ll_lives", 32'(lives), 32'd3);
        chk("rs_ll_game_over", 32'(game_over), 32'd0);
        pix_on("rs_ll_h0", 20, 20, 1'b1);
        pix_on("rs_ll_h1", 40, 20, 1'b1);
        pix_on("rs_ll_h2", 60, 20, 1'b1);

        // Loss and frame_start together: counter reloads instead of decrementing.
        lose;
        for (int n = 0; n < 5; n++) frame;
        frame_start = 1'b1;
        life_lost   = 1'b1;
        tick;
        frame_start = 1'b0;
        life_lost   = 1'b0;
        chk("ll_fs_lives", 32'(lives), 32'd1);
        frame;
        pix_on("ll_fs_h1_cnt31", 40, 20, 1'b1);
        pix_on("ll_fs_h2_gone", 60, 20, 1'b0);

        // Reset in the middle of a blink.
        do_restart;
        lose;
        frame;
        pix_on("pre_reset_h2_blink_on", 60, 20, 1'b1);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("mid_reset_lives", 32'(lives), 32'd3);
        chk("mid_reset_heart_on", 32'(heart_on), 32'd0);
        for (int n = 0; n < 4; n++) frame;
        pix_on("post_reset_h2_solid", 60, 20, 1'b1);
        chk("post_reset_lives", 32'(lives), 32'd3);
        chk("post_reset_game_over", 32'(game_over), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
